esc_quad_drv: RTL

Four-channel ESC pulse driver at the output end of the flight controller. It accepts the four 11-bit motor speeds (front, back, left, right) that the flight controller produces each time it completes an update. It converts them into servo-style PWM pulses, one per ESC, on a fixed frame period. Speeds are double-buffered so a pulse never changes width mid-frame. A frame watchdog forces all motors to minimum pulse if the controller stops updating.

---
 rtl/esc_pkg.sv | 14 +
 rtl/esc_pwm_chan.sv | 58 +++++
 rtl/esc_quad_drv.sv | 113 +++++++++++
 3 files changed

// File: rtl/esc_pkg.sv
// Shared speed width, speed type and channel naming for the quad ESC driver.
package esc_pkg;
    localparam int SPD_W    = 11;
    localparam int NUM_CHAN = 4;

    typedef logic [SPD_W-1:0] spd_t;

    typedef enum logic [1:0] {
        FRNT = 2'd0,
        BCK  = 2'd1,
        LFT  = 2'd2,
        RGHT = 2'd3
    } chan_e;
endpackage

// File: rtl/esc_pwm_chan.sv
// One ESC channel: shadow/active speed registers, pulse width computation and
// the registered compare against the upcoming frame count.
module esc_pwm_chan
    import esc_pkg::*;
#(
    parameter int PERIOD_W  = 20,
    parameter int MIN_PULSE = 50000,
    parameter int SCALE     = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cap,
    input  logic                i_ld_byp,
    input  logic                i_ld_shd,
    input  logic                i_clr,
    input  spd_t                i_spd,
    input  logic [PERIOD_W-1:0] i_cnt_nxt,
    output logic                o_pwm
);
    localparam logic [PERIOD_W-1:0] MIN_W   = PERIOD_W'(MIN_PULSE);
    localparam logic [PERIOD_W-1:0] SCALE_W = PERIOD_W'(SCALE);

    spd_t                r_shadow;
    spd_t                r_active;
    spd_t                w_act_nxt;
    logic [PERIOD_W-1:0] w_width;
    logic                r_pwm;

    always_comb begin
        w_act_nxt = r_active;
        if (i_ld_byp) begin
            w_act_nxt = i_spd;
        end else if (i_ld_shd) begin
            w_act_nxt = r_shadow;
        end else if (i_clr) begin
            w_act_nxt = '0;
        end
    end

    // Width follows the next active value so a new speed takes effect on the frame's first edge
    assign w_width = MIN_W + PERIOD_W'(w_act_nxt) * SCALE_W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_cap) begin
                r_shadow <= i_spd;
            end
            r_active <= w_act_nxt;
            r_pwm    <= (i_cnt_nxt < w_width);
        end
    end

    assign o_pwm = r_pwm;
endmodule

// File: rtl/esc_quad_drv.sv
// Four-channel ESC PWM driver: free-running frame counter, double-buffered
// speed loads at the frame wrap, and a frame watchdog that forces minimum pulses.
module esc_quad_drv
    import esc_pkg::*;
#(
    parameter int PERIOD_W  = 20,
    parameter int MIN_PULSE = 50000,
    parameter int SCALE     = 24,
    parameter int WD_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic [SPD_W-1:0] frnt_spd,
    input  logic [SPD_W-1:0] bck_spd,
    input  logic [SPD_W-1:0] lft_spd,
    input  logic [SPD_W-1:0] rght_spd,
    output logic             frnt,
    output logic             bck,
    output logic             lft,
    output logic             rght,
    output logic             frame_start,
    output logic             stale
);
    localparam int                  WD_W    = $clog2(WD_FRAMES + 1);
    localparam logic [WD_W-1:0]     WD_MAX  = WD_W'(WD_FRAMES);
    localparam logic [WD_W-1:0]     WD_ONE  = WD_W'(1);
    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_cnt_nxt;
    logic [WD_W-1:0]     r_wd;
    logic                r_pending;
    logic                r_stale;
    logic                r_frame_start;
    logic                w_wrap;
    logic                w_ld_byp;
    logic                w_ld_shd;
    logic                w_load;
    logic                w_trip;
    spd_t                w_spd [NUM_CHAN];
    logic [NUM_CHAN-1:0] w_pwm;

    assign w_cnt_nxt = r_cnt + CNT_ONE;
    assign w_wrap    = &r_cnt;
    assign w_ld_byp  = w_wrap & upd;
    assign w_ld_shd  = w_wrap & ~upd & r_pending;
    assign w_load    = w_ld_byp | w_ld_shd;
    // Trips on a non-loading wrap once WD_FRAMES idle wraps have already gone by
    assign w_trip    = w_wrap & ~w_load & (r_wd == WD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_wd          <= '0;
            r_pending     <= 1'b0;
            r_stale       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_frame_start <= w_wrap;
            if (w_wrap) begin
                r_pending <= 1'b0;
            end else if (upd) begin
                r_pending <= 1'b1;
            end
            if (w_load) begin
                r_wd <= '0;
            end else if (w_wrap) begin
                if (r_wd != WD_MAX) begin
                    r_wd <= r_wd + WD_ONE;
                end
            end else if (upd) begin
                r_wd <= '0;
            end
            if (w_load) begin
                r_stale <= 1'b0;
            end else if (w_trip) begin
                r_stale <= 1'b1;
            end
        end
    end

    assign w_spd[FRNT] = frnt_spd;
    assign w_spd[BCK]  = bck_spd;
    assign w_spd[LFT]  = lft_spd;
    assign w_spd[RGHT] = rght_spd;

    for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
        esc_pwm_chan #(
            .PERIOD_W  (PERIOD_W),
            .MIN_PULSE (MIN_PULSE),
            .SCALE     (SCALE)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_cap     (upd),
            .i_ld_byp  (w_ld_byp),
            .i_ld_shd  (w_ld_shd),
            .i_clr     (w_trip),
            .i_spd     (w_spd[g]),
            .i_cnt_nxt (w_cnt_nxt),
            .o_pwm     (w_pwm[g])
        );
    end

    assign frnt        = w_pwm[FRNT];
    assign bck         = w_pwm[BCK];
    assign lft         = w_pwm[LFT];
    assign rght        = w_pwm[RGHT];
    assign frame_start = r_frame_start;
    assign stale       = r_stale;
endmodule
